// File: rtl/dualport_bram_clr.sv
`default_nettype none
// ============================================================================
// Module   : dualport_bram_clr
// Purpose  : True dual-port block RAM with byte-enable writes, selectable
//            read latency (1 or 2), per-port read-during-write mode, a
//            cross-port collision flag and a hardware clear engine that fills
//            the array with INIT_VALUE after reset or on request.
// Ports    : clk_i, rst_i      - clock / synchronous active-high reset
//            clear_i, busy_o   - clear-sweep request / sweep in progress
//            a_* / b_*         - en, byte we, addr, din, dout, valid per port
//            collision_o       - same-address A/B access with a write, 1 cycle
// Revision : 1.0 - initial release
// ============================================================================
module dualport_bram_clr #(
    parameter int    ADDR_WIDTH   = 8,
    parameter int    MEM_DEPTH    = 2**ADDR_WIDTH,
    parameter int    DATA_WIDTH   = 32,
    parameter int    BYTE_WIDTH   = 8,
    parameter int    READ_LATENCY = 1,
    parameter string WRITE_MODE_A = "READ_FIRST",
    parameter string WRITE_MODE_B = "READ_FIRST",
    parameter logic  INIT_VALUE   = 1'b0,
    localparam int   NB           = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    output logic                  busy_o,

    input  logic                  a_en_i,
    input  logic [NB-1:0]         a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_din_i,
    output logic [DATA_WIDTH-1:0] a_dout_o,
    output logic                  a_valid_o,

    input  logic                  b_en_i,
    input  logic [NB-1:0]         b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_din_i,
    output logic [DATA_WIDTH-1:0] b_dout_o,
    output logic                  b_valid_o,

    output logic                  collision_o
);

    localparam logic [0:0]            STATE_CLEAR = 1'b0;
    localparam logic [0:0]            STATE_IDLE  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam bit                    A_WRITE_FIRST = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit                    B_WRITE_FIRST = (WRITE_MODE_B == "WRITE_FIRST");

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy;
    logic                  clr_we;

    // ------------------------------------------------------------------
    // Clear-engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= STATE_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STATE_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = STATE_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STATE_IDLE: begin
                if (clear_i) begin
                    state_d = STATE_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = STATE_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == STATE_CLEAR);
        clr_we = (state_q == STATE_CLEAR);
    end

    assign busy_o = busy;

    // ------------------------------------------------------------------
    // Access qualification and read-data formation
    // ------------------------------------------------------------------
    logic                  a_acc, b_acc;
    logic                  a_in_range, b_in_range;
    logic                  a_wr, b_wr;
    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic [DATA_WIDTH-1:0] a_merge, b_merge;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

    assign a_acc      = a_en_i & ~busy;
    assign b_acc      = b_en_i & ~busy;
    assign a_in_range = ({1'b0, a_addr_i} < DEPTH_EXT);
    assign b_in_range = ({1'b0, b_addr_i} < DEPTH_EXT);
    assign a_wr       = a_acc & a_in_range;
    assign b_wr       = b_acc & b_in_range;

    // Out-of-range reads return zero rather than an aliased word.
    assign a_old = a_in_range ? mem_q[a_addr_i] : '0;
    assign b_old = b_in_range ? mem_q[b_addr_i] : '0;

    // Merged word seen by a WRITE_FIRST port: only its own written bytes are
    // new, so a simultaneous write from the other port is never forwarded.
    always_comb begin
        a_merge = a_old;
        b_merge = b_old;
        for (int k = 0; k < NB; k++) begin
            if (a_we_i[k]) begin
                a_merge[k*BYTE_WIDTH +: BYTE_WIDTH] = a_din_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (b_we_i[k]) begin
                b_merge[k*BYTE_WIDTH +: BYTE_WIDTH] = b_din_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign a_rdata = (A_WRITE_FIRST && a_in_range) ? a_merge : a_old;
    assign b_rdata = (B_WRITE_FIRST && b_in_range) ? b_merge : b_old;

    // ------------------------------------------------------------------
    // Memory array (not reset; the clear engine initialises it). Port B's
    // byte writes are issued after port A's, so B wins on shared bytes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[cnt_q] <= {DATA_WIDTH{INIT_VALUE}};
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (a_wr && a_we_i[k]) begin
                    mem_q[a_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= a_din_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int k = 0; k < NB; k++) begin
                if (b_wr && b_we_i[k]) begin
                    mem_q[b_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= b_din_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // First read stage; data registers hold their last value when idle.
    // ------------------------------------------------------------------
    logic                  a_v1_q, b_v1_q;
    logic [DATA_WIDTH-1:0] a_d1_q, b_d1_q;
    logic                  collision_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_v1_q      <= 1'b0;
            b_v1_q      <= 1'b0;
            a_d1_q      <= '0;
            b_d1_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            a_v1_q      <= a_acc;
            b_v1_q      <= b_acc;
            if (a_acc) a_d1_q <= a_rdata;
            if (b_acc) b_d1_q <= b_rdata;
            collision_q <= a_acc & b_acc & (a_addr_i == b_addr_i) & ((|a_we_i) | (|b_we_i));
        end
    end

    assign collision_o = collision_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  a_v2_q, b_v2_q;
            logic [DATA_WIDTH-1:0] a_d2_q, b_d2_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_v2_q <= 1'b0;
                    b_v2_q <= 1'b0;
                    a_d2_q <= '0;
                    b_d2_q <= '0;
                end else begin
                    a_v2_q <= a_v1_q;
                    b_v2_q <= b_v1_q;
                    if (a_v1_q) a_d2_q <= a_d1_q;
                    if (b_v1_q) b_d2_q <= b_d1_q;
                end
            end

            assign a_valid_o = a_v2_q;
            assign a_dout_o  = a_d2_q;
            assign b_valid_o = b_v2_q;
            assign b_dout_o  = b_d2_q;
        end else begin : g_lat1
            assign a_valid_o = a_v1_q;
            assign a_dout_o  = a_d1_q;
            assign b_valid_o = b_v1_q;
            assign b_dout_o  = b_d1_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dualport_bram_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_dualport_bram_clr
// Purpose  : Self-checking bench for dualport_bram_clr. Instance 0 uses the
//            default configuration (depth 256, latency 1, READ_FIRST, init 0);
//            instance 1 uses depth 200, latency 2, WRITE_FIRST on port A and
//            init value 1. Read results are queued at issue and popped when
//            the matching valid pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dualport_bram_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clr   [2];
    logic        aen   [2];
    logic [3:0]  awe   [2];
    logic [7:0]  aaddr [2];
    logic [31:0] adin  [2];
    logic [31:0] adout [2];
    logic        avalid[2];
    logic        ben   [2];
    logic [3:0]  bwe   [2];
    logic [7:0]  baddr [2];
    logic [31:0] bdin  [2];
    logic [31:0] bdout [2];
    logic        bvalid[2];
    logic        busy  [2];
    logic        coll  [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [2][256];
    logic [31:0] qa0[$], qb0[$], qa1[$], qb1[$];

    dualport_bram_clr #(
        .ADDR_WIDTH(8), .MEM_DEPTH(256), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
        .INIT_VALUE(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[0]), .busy_o(busy[0]),
        .a_en_i(aen[0]), .a_we_i(awe[0]), .a_addr_i(aaddr[0]), .a_din_i(adin[0]),
        .a_dout_o(adout[0]), .a_valid_o(avalid[0]),
        .b_en_i(ben[0]), .b_we_i(bwe[0]), .b_addr_i(baddr[0]), .b_din_i(bdin[0]),
        .b_dout_o(bdout[0]), .b_valid_o(bvalid[0]),
        .collision_o(coll[0])
    );

    dualport_bram_clr #(
        .ADDR_WIDTH(8), .MEM_DEPTH(200), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
        .INIT_VALUE(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[1]), .busy_o(busy[1]),
        .a_en_i(aen[1]), .a_we_i(awe[1]), .a_addr_i(aaddr[1]), .a_din_i(adin[1]),
        .a_dout_o(adout[1]), .a_valid_o(avalid[1]),
        .b_en_i(ben[1]), .b_we_i(bwe[1]), .b_addr_i(baddr[1]), .b_din_i(bdin[1]),
        .b_dout_o(bdout[1]), .b_valid_o(bvalid[1]),
        .collision_o(coll[1])
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (we[k]) r[k*8 +: 8] = din[k*8 +: 8];
        return r;
    endfunction

    task automatic model_fill(input int i, input logic [31:0] v);
        for (int a = 0; a < 256; a++) mdl[i][a] = v;
    endtask

    // Scoreboard: pop on every valid pulse, one sample #1 after each edge.
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (avalid[0]) begin
            checks++;
            if (qa0.size() == 0) begin errors++; $display("FAIL a0_unexpected_valid got=%h", adout[0]); end
            else begin e = qa0.pop_front(); if (adout[0] !== e) begin errors++; $display("FAIL a0_rdata got=%h exp=%h", adout[0], e); end end
        end
        if (bvalid[0]) begin
            checks++;
            if (qb0.size() == 0) begin errors++; $display("FAIL b0_unexpected_valid got=%h", bdout[0]); end
            else begin e = qb0.pop_front(); if (bdout[0] !== e) begin errors++; $display("FAIL b0_rdata got=%h exp=%h", bdout[0], e); end end
        end
        if (avalid[1]) begin
            checks++;
            if (qa1.size() == 0) begin errors++; $display("FAIL a1_unexpected_valid got=%h", adout[1]); end
            else begin e = qa1.pop_front(); if (adout[1] !== e) begin errors++; $display("FAIL a1_rdata got=%h exp=%h", adout[1], e); end end
        end
        if (bvalid[1]) begin
            checks++;
            if (qb1.size() == 0) begin errors++; $display("FAIL b1_unexpected_valid got=%h", bdout[1]); end
            else begin e = qb1.pop_front(); if (bdout[1] !== e) begin errors++; $display("FAIL b1_rdata got=%h exp=%h", bdout[1], e); end end
        end
    end

    // One-cycle access on instance i; called #1 after a rising edge and
    // returns #1 after the next one. acc=0 means the DUT is busy and must
    // ignore the access entirely.
    task automatic access(input int i,
                          input logic ae, input logic [3:0] aw, input logic [7:0] aa, input logic [31:0] ad,
                          input logic be, input logic [3:0] bw, input logic [7:0] ba, input logic [31:0] bd,
                          input bit acc);
        int          depth;
        bit          ina, inb;
        logic        ec;
        logic [31:0] ra, rb;
        depth = (i == 0) ? 256 : 200;
        aen[i] = ae; awe[i] = aw; aaddr[i] = aa; adin[i] = ad;
        ben[i] = be; bwe[i] = bw; baddr[i] = ba; bdin[i] = bd;
        ec = 1'b0;
        if (acc) begin
            ina = (int'(aa) < depth);
            inb = (int'(ba) < depth);
            ra = ina ? mdl[i][aa] : 32'h0;
            if (i == 1 && ina) ra = merge(ra, ad, aw);
            rb = inb ? mdl[i][ba] : 32'h0;
            if (ae) begin if (i == 0) qa0.push_back(ra); else qa1.push_back(ra); end
            if (be) begin if (i == 0) qb0.push_back(rb); else qb1.push_back(rb); end
            ec = ae && be && (aa == ba) && (aw != 4'h0 || bw != 4'h0);
            if (ae && ina) mdl[i][aa] = merge(mdl[i][aa], ad, aw);
            if (be && inb) mdl[i][ba] = merge(mdl[i][ba], bd, bw);
        end
        @(posedge clk); #1;
        aen[i] = 1'b0; awe[i] = 4'h0; ben[i] = 1'b0; bwe[i] = 4'h0;
        checks++;
        if (coll[i] !== ec) begin
            errors++;
            $display("FAIL collision_%0d got=%b exp=%b", i, coll[i], ec);
        end
    endtask

    // Counts rising edges until both instances are idle (0 if already idle).
    task automatic count_busy(output int n0, output int n1);
        int n;
        n = 0; n0 = 0; n1 = 0;
        while ((busy[0] || busy[1]) && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (!busy[0] && n0 == 0) n0 = n;
            if (!busy[1] && n1 == 0) n1 = n;
        end
        if (n >= 2000) begin
            errors++;
            $display("FAIL busy_timeout busy0=%b busy1=%b", busy[0], busy[1]);
        end
    endtask

    task automatic test_reset();
        int n0, n1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (busy[i] !== 1'b1) begin errors++; $display("FAIL reset_busy_%0d got=%b exp=1", i, busy[i]); end
            checks++; if (avalid[i] !== 1'b0 || bvalid[i] !== 1'b0) begin errors++; $display("FAIL reset_valid_%0d got=%b%b exp=00", i, avalid[i], bvalid[i]); end
            checks++; if (adout[i] !== 32'h0 || bdout[i] !== 32'h0) begin errors++; $display("FAIL reset_dout_%0d got=%h/%h exp=0", i, adout[i], bdout[i]); end
            checks++; if (coll[i] !== 1'b0) begin errors++; $display("FAIL reset_coll_%0d got=%b exp=0", i, coll[i]); end
        end
        rst = 1'b0;
        model_fill(0, 32'h0);
        model_fill(1, 32'hFFFF_FFFF);
        count_busy(n0, n1);
        checks++; if (n0 != 256) begin errors++; $display("FAIL reset_sweep_len0 got=%0d exp=256", n0); end
        checks++; if (n1 != 200) begin errors++; $display("FAIL reset_sweep_len1 got=%0d exp=200", n1); end
        for (int a = 0; a < 256; a++) begin
            access(0, 1'b1, 4'h0, 8'(a), 32'h0, 1'b1, 4'h0, 8'(255 - a), 32'h0, 1'b1);
            if (a == 0) begin
                checks++;
                if (avalid[0] !== 1'b1) begin errors++; $display("FAIL read_latency1 got=%b exp=1", avalid[0]); end
            end
        end
        for (int a = 0; a < 200; a++)
            access(1, 1'b1, 4'h0, 8'(a), 32'h0, 1'b1, 4'h0, 8'(199 - a), 32'h0, 1'b1);
    endtask

    task automatic test_byte_enable();
        access(0, 1'b1, 4'hF,    8'd5, 32'hDEAD_BEEF, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        access(0, 1'b1, 4'b0010, 8'd5, 32'h0000_AA00, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        access(0, 1'b0, 4'h0,    8'd0, 32'h0,         1'b1, 4'h0, 8'd5, 32'h0, 1'b1);
        checks++;
        if (bvalid[0] !== 1'b1 || bdout[0] !== 32'hDEAD_AAEF) begin
            errors++; $display("FAIL byte_enable got=%b/%h exp=1/deadaaef", bvalid[0], bdout[0]);
        end
    endtask

    task automatic test_read_latency();
        access(1, 1'b1, 4'hF, 8'd5, 32'hCAFE_F00D, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        access(1, 1'b1, 4'h0, 8'd5, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        checks++;
        if (avalid[1] !== 1'b0) begin errors++; $display("FAIL latency2_early got=%b exp=0", avalid[1]); end
        @(posedge clk); #1;
        checks++;
        if (avalid[1] !== 1'b1 || adout[1] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL latency2_data got=%b/%h exp=1/cafef00d", avalid[1], adout[1]);
        end
    endtask

    task automatic test_collision();
        access(0, 1'b1, 4'hF, 8'd9, 32'h1111_1111, 1'b1, 4'hF, 8'd9, 32'h2222_2222, 1'b1);
        access(0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd9, 32'h0, 1'b1);
        checks++;
        if (bdout[0] !== 32'h2222_2222) begin errors++; $display("FAIL ww_b_wins got=%h exp=22222222", bdout[0]); end
        // write vs read: reader sees old word, flag raised
        access(0, 1'b1, 4'hF, 8'd9, 32'h3333_3333, 1'b1, 4'h0, 8'd9, 32'h0, 1'b1);
        checks++;
        if (bdout[0] !== 32'h2222_2222) begin errors++; $display("FAIL wr_reader_old got=%h exp=22222222", bdout[0]); end
        // read vs read: no flag
        access(0, 1'b1, 4'h0, 8'd9, 32'h0, 1'b1, 4'h0, 8'd9, 32'h0, 1'b1);
        // per-byte resolution on addr 10 (zero): 00 BB BB AA
        access(0, 1'b1, 4'b0011, 8'd10, 32'hAAAA_AAAA, 1'b1, 4'b0110, 8'd10, 32'hBBBB_BBBB, 1'b1);
        access(0, 1'b1, 4'h0, 8'd10, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        checks++;
        if (adout[0] !== 32'h00BB_BBAA) begin errors++; $display("FAIL ww_bytes got=%h exp=00bbbbaa", adout[0]); end
        // different addresses: no flag
        access(0, 1'b1, 4'hF, 8'd11, 32'h5555_5555, 1'b1, 4'hF, 8'd12, 32'h6666_6666, 1'b1);
    endtask

    task automatic test_write_mode();
        access(0, 1'b1, 4'hF, 8'd3, 32'hAAAA_5555, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        access(0, 1'b1, 4'hF, 8'd3, 32'h1234_5678, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        checks++;
        if (adout[0] !== 32'hAAAA_5555) begin errors++; $display("FAIL read_first got=%h exp=aaaa5555", adout[0]); end
        access(1, 1'b1, 4'hF, 8'd3, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        access(1, 1'b1, 4'hF, 8'd3, 32'h1234_5678, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (adout[1] !== 32'h1234_5678) begin errors++; $display("FAIL write_first got=%h exp=12345678", adout[1]); end
        access(1, 1'b1, 4'b0001, 8'd3, 32'h0000_00FF, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        access(1, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'hF, 8'd4, 32'h4444_4444, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_out_of_range();
        access(1, 1'b1, 4'hF, 8'd210, 32'hDEAD_BEEF, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        access(1, 1'b1, 4'h0, 8'd210, 32'h0, 1'b1, 4'h0, 8'd10, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (avalid[1] !== 1'b1 || adout[1] !== 32'h0) begin
            errors++; $display("FAIL oor_read got=%b/%h exp=1/00000000", avalid[1], adout[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int n0, n1;
        access(0, 1'b1, 4'hF, 8'd7, 32'h7777_7777, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        // read accepted in the same cycle the sweep starts still completes
        clr[0] = 1'b1;
        access(0, 1'b1, 4'h0, 8'd7, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        clr[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL clear_busy got=%b exp=1", busy[0]); end
        model_fill(0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            clr[0] = (k == 2);
            access(0, 1'b1, 4'hF, 8'(k + 7), 32'hBAD0_0000, 1'b1, 4'hF, 8'(k + 20), 32'hBAD1_1111, 1'b0);
        end
        clr[0] = 1'b0;
        count_busy(n0, n1);
        checks++;
        if (n0 + 5 != 256) begin errors++; $display("FAIL clear_sweep_len got=%0d exp=256", n0 + 5); end
        for (int k = 0; k < 8; k++)
            access(0, 1'b1, 4'h0, 8'(k + 5), 32'h0, 1'b1, 4'h0, 8'(k + 20), 32'h0, 1'b1);
        access(0, 1'b1, 4'h0, 8'd255, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        // latency-2 instance: in-flight read pulses while already busy
        clr[1] = 1'b1;
        access(1, 1'b1, 4'h0, 8'd5, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        clr[1] = 1'b0;
        model_fill(1, 32'hFFFF_FFFF);
        count_busy(n0, n1);
        checks++;
        if (n1 != 200) begin errors++; $display("FAIL clear_sweep_len1 got=%0d exp=200", n1); end
        access(1, 1'b1, 4'h0, 8'd5, 32'h0, 1'b1, 4'h0, 8'd199, 32'h0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset_mid_sweep();
        int n0, n1;
        access(0, 1'b1, 4'hF, 8'd20, 32'h2020_2020, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1);
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_fill(0, 32'h0);
        model_fill(1, 32'hFFFF_FFFF);
        count_busy(n0, n1);
        checks++;
        if (n0 != 256) begin errors++; $display("FAIL restart_sweep_len got=%0d exp=256", n0); end
        checks++;
        if (n1 != 200) begin errors++; $display("FAIL restart_sweep_len1 got=%0d exp=200", n1); end
        access(0, 1'b1, 4'h0, 8'd20, 32'h0, 1'b1, 4'h0, 8'd255, 32'h0, 1'b1);
        checks++;
        if (adout[0] !== 32'h0) begin errors++; $display("FAIL restart_cleared got=%h exp=0", adout[0]); end
        access(1, 1'b1, 4'h0, 8'd5, 32'h0, 1'b1, 4'h0, 8'd3, 32'h0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0;
            aen[i] = 1'b0; awe[i] = 4'h0; aaddr[i] = 8'h0; adin[i] = 32'h0;
            ben[i] = 1'b0; bwe[i] = 4'h0; baddr[i] = 8'h0; bdin[i] = 32'h0;
        end
        test_reset();
        test_byte_enable();
        test_read_latency();
        test_collision();
        test_write_mode();
        test_out_of_range();
        test_clear();
        test_reset_mid_sweep();
        checks++;
        if (qa0.size() + qb0.size() + qa1.size() + qb1.size() != 0) begin
            errors++;
            $display("FAIL pending_reads got=%0d exp=0", qa0.size() + qb0.size() + qa1.size() + qb1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
